// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with glitch rejection, parity/framing flags and an FWFT output FIFO.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         uart_rx,
  input  logic                         out_ready,
  input  logic                         clr_overrun,
  output logic                         out_valid,
  output logic [DATA_BITS-1:0]         out_data,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         overrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int W   = DATA_BITS + 2;
  localparam logic [15:0] HALF = 16'(CPB / 2 - 1);
  localparam logic [15:0] FULL = 16'(CPB - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, armed_q, armed_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, brk_q, brk_d, push;
  logic [W-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]          count_q, count_d;
  logic                 ovr_q, ovr_d, pop, full, wr_en;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    brk_d   = brk_q;
    push    = 1'b0;
    armed_d = armed_q | rx_s_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (armed_q && !rx_s_q) begin
          state_d = S_START;
          perr_d  = 1'b0;
        end
      end
      S_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (cnt_q == FULL) begin
        cnt_d   = '0;
        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
        idx_d   = idx_q + 1'b1;
        if (idx_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: if (cnt_q == FULL) begin
        cnt_d   = '0;
        perr_d  = ((^shift_q) ^ rx_s_q) != (PARITY == 1);
        state_d = S_STOP;
      end
      S_STOP: begin
        // A zero stop bit pushes once, then the line must return high before the next frame.
        if (brk_q) begin
          cnt_d = '0;
          if (rx_s_q) begin
            brk_d   = 1'b0;
            state_d = S_IDLE;
          end
        end else if (cnt_q == FULL) begin
          cnt_d   = '0;
          push    = 1'b1;
          brk_d   = !rx_s_q;
          state_d = rx_s_q ? S_IDLE : S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    pop     = out_valid && out_ready;
    full    = count_q == (AW+1)'(FIFO_DEPTH);
    wr_en   = push && (!full || pop);
    wr_d    = wr_q + AW'(wr_en);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    ovr_d   = (push && full && !pop) || (ovr_q && !clr_overrun);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      armed_q   <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      brk_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      armed_q   <= armed_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      brk_q     <= brk_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {shift_q, ~rx_s_q, perr_q};
  end
  assign out_valid  = count_q != '0;
  assign {out_data, frame_err, parity_err} = out_valid ? mem_q[rd_q] : '0;
  assign overrun    = ovr_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized frames on an 8N1 and a 7E1 receiver, checked against a queue-based word model.
module tb_uart_rx_fifo;
  logic clk = 1'b0, rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b0, rdy_b = 1'b1, clr_a = 1'b0, clr_b = 1'b0;
  logic val_a, fe_a, pe_a, ov_a, val_b, fe_b, pe_b, ov_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [2:0] cnt_a, cnt_b;
  int n_chk = 0, n_err = 0;
  int qa[$], qb[$];
  int ov_exp = 0;
  always #5 clk = ~clk;
  uart_rx_fifo #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .uart_rx(rx_a), .out_ready(rdy_a), .clr_overrun(clr_a),
    .out_valid(val_a), .out_data(data_a), .frame_err(fe_a), .parity_err(pe_a),
    .overrun(ov_a), .fifo_count(cnt_a));
  uart_rx_fifo #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .uart_rx(rx_b), .out_ready(rdy_b), .clr_overrun(clr_b),
    .out_valid(val_b), .out_data(data_b), .frame_err(fe_b), .parity_err(pe_b),
    .overrun(ov_b), .fifo_count(cnt_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask
  // Word layout {data, frame_err, parity_err}; B uses even parity over 7 data bits.
  function automatic int exp_word(input bit sel, input int data, input bit par, input bit stop);
    int pe = 0;
    if (sel) pe = (($countones(data & 'h7f) + int'(par)) % 2 != 0) ? 1 : 0;
    return ((sel ? (data & 'h7f) : (data & 'hff)) << 2) | ((stop ? 0 : 1) << 1) | pe;
  endfunction
  task automatic model_push(input bit sel, input int w);
    if (sel) qb.push_back(w);
    else if (qa.size() >= 4) ov_exp = 1;
    else qa.push_back(w);
  endtask
  task automatic send(input bit sel, input int data, input bit par, input bit stop);
    int n = sel ? 7 : 8;
    drive(sel, 1'b0);
    repeat (10) tick();
    for (int i = 0; i < n; i++) begin
      drive(sel, logic'((data >> i) & 1));
      repeat (10) tick();
    end
    if (sel) begin
      drive(sel, par);
      repeat (10) tick();
    end
    model_push(sel, exp_word(sel, data, par, stop));
    drive(sel, stop);
    repeat (10) tick();
    if (!stop) begin
      repeat ($urandom_range(0, 30)) tick();
      drive(sel, 1'b1);
      repeat (12) tick();
    end
    drive(sel, 1'b1);
    repeat (3) tick();
  endtask
  always @(negedge clk) begin
    if (val_a && rdy_a) begin
      if (qa.size() == 0) chk("pop_a_unexpected", 1, 0);
      else chk("pop_a", {22'd0, data_a, fe_a, pe_a}, qa.pop_front());
    end
    if (val_b && rdy_b) begin
      if (qb.size() == 0) chk("pop_b_unexpected", 1, 0);
      else chk("pop_b", {23'd0, data_b, fe_b, pe_b}, qb.pop_front());
    end
  end
  initial begin
    repeat (3) tick();
    chk("rst_valid", val_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_flags", {fe_a, pe_a, ov_a}, 0);
    rst = 1'b0;
    repeat (3) tick();
    send(0, 'hA5, 0, 1);
    repeat (2) tick();
    chk("t1_valid", val_a, 1);
    chk("t1_count", cnt_a, 1);
    chk("t1_data", data_a, 'hA5);
    chk("t1_flags", {fe_a, pe_a}, 0);
    rdy_a = 1'b1;
    tick();
    chk("t1_pop_valid", val_a, 0);
    chk("t1_pop_count", cnt_a, 0);
    rx_a = 1'b0;
    repeat (3) tick();
    rx_a = 1'b1;
    repeat (20) tick();
    chk("t2_glitch_count", cnt_a, 0);
    chk("t2_glitch_valid", val_a, 0);
    send(1, 'h07, 0, 1);
    send(1, 'h07, 1, 1);
    repeat (2) tick();
    chk("t3_b_drained", qb.size(), 0);
    qa.push_back(exp_word(0, 0, 0, 0));
    rx_a = 1'b0;
    repeat (300) tick();
    rx_a = 1'b1;
    repeat (12) tick();
    send(0, 'h3C, 0, 1);
    repeat (2) tick();
    chk("t4_words_left", qa.size(), 0);
    chk("t4_count", cnt_a, 0);
    rdy_a = 1'b0;
    for (int d = 1; d <= 5; d++) send(0, d, 0, 1);
    chk("t5_count", cnt_a, 4);
    chk("t5_overrun", ov_a, ov_exp);
    chk("t5_data_head", data_a, 1);
    rdy_a = 1'b1;
    repeat (8) tick();
    rdy_a = 1'b0;
    chk("t5_drained", qa.size(), 0);
    chk("t5_count_after", cnt_a, 0);
    chk("t5_overrun_sticky", ov_a, 1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    ov_exp = 0;
    chk("t5_overrun_clr", ov_a, ov_exp);
    send(0, 'h11, 0, 1);
    chk("t6_pre_count", cnt_a, 1);
    rx_a = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 3; i++) begin
      rx_a = logic'(('h55 >> i) & 1);
      repeat (10) tick();
    end
    rst = 1'b1;
    qa.delete();
    qb.delete();
    tick();
    chk("t6_rst_valid", val_a, 0);
    chk("t6_rst_count", cnt_a, 0);
    chk("t6_rst_data", data_a, 0);
    chk("t6_rst_flags", {fe_a, pe_a, ov_a}, 0);
    rx_a = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t6_after_count", cnt_a, 0);
    rdy_a = 1'b1;
    send(0, 'h9E, 0, 1);
    repeat (3) tick();
    chk("t6_9e_received", qa.size(), 0);
    for (int k = 0; k < 16; k++) send(0, $urandom_range(0, 255), 0, $urandom_range(0, 4) != 0);
    for (int k = 0; k < 8; k++) send(1, $urandom_range(0, 127), 1'($urandom_range(0, 1)), 1);
    repeat (5) tick();
    chk("end_qa_empty", qa.size(), 0);
    chk("end_qb_empty", qb.size(), 0);
    chk("end_cnt_a", cnt_a, 0);
    chk("end_cnt_b", cnt_b, 0);
    chk("end_ov_b", ov_b, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
